// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared constants and state type for the one-hot decode accumulator
package decoder_pkg;

  localparam int SEL_W_DEF     = 3;
  localparam int FRAME_LEN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/decoder3to8.sv
// rtl/decoder3to8.sv - combinational SEL_W-to-2**SEL_W one-hot decoder with enable
module decoder3to8
#(
  parameter  int SEL_W = 3,
  localparam int VEC_W = 2**SEL_W
)(
  input  logic             en,
  input  logic [SEL_W-1:0] code,
  output logic [VEC_W-1:0] vec
);

  // Drive a single bit for the selected index; all zeros when disabled
  always_comb begin
    vec = '0;
    if (en) begin
      vec[code] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder3to8_accum.sv
// rtl/decoder3to8_accum.sv - accumulates decoded one-hot codes into framed request vectors (option: DECODE_ACCUM_DUP_DETECT_EN)
module decoder3to8_accum
  import decoder_pkg::*;
#(
  parameter  int SEL_W     = SEL_W_DEF,
  parameter  int FRAME_LEN = FRAME_LEN_DEF,
  localparam int VEC_W     = 2**SEL_W,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_code,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_vec,
  output logic [CNT_W-1:0] out_count
`ifdef DECODE_ACCUM_DUP_DETECT_EN
  ,
  output logic             out_dup
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN);

  state_t           state;
  logic [VEC_W-1:0] acc;
  logic [VEC_W-1:0] dec_vec;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             in_fire;
  logic             out_fire;
  logic             frame_close;

  assign in_ready    = (state != HOLD);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign cnt_nxt     = cnt + CNT_W'(1);
  // in_last and reaching FRAME_LEN on the same code are one close, not two
  assign frame_close = in_last || (cnt_nxt == CNT_MAX);

  // Decoder is enabled only on a transfer, so dec_vec is zero otherwise
  decoder3to8 #(
    .SEL_W (SEL_W)
  ) u_dec (
    .en   (in_fire),
    .code (in_code),
    .vec  (dec_vec)
  );

  // Frame FSM: accumulate codes, snapshot the frame on close, release on output transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (in_fire) begin
            acc <= acc | dec_vec;
            cnt <= cnt_nxt;
            if (frame_close) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_vec   <= acc | dec_vec;
              out_count <= cnt_nxt;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_fire) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DECODE_ACCUM_DUP_DETECT_EN
  logic dup_seen;
  logic dup_hit;

  // A duplicate is a decoded bit landing on one already held in acc
  assign dup_hit = |(acc & dec_vec);

  // Track duplicates across the frame and publish the flag alongside out_vec
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dup_seen <= 1'b0;
      out_dup  <= 1'b0;
    end else if (in_fire) begin
      dup_seen <= dup_seen | dup_hit;
      if (frame_close) begin
        out_dup <= dup_seen | dup_hit;
      end
    end else if (out_fire) begin
      dup_seen <= 1'b0;
      out_dup  <= 1'b0;
    end
  end
`else
  // No duplicate tracking in this build
`endif

endmodule

// File: doc/decoder3to8_accum.md
Name: decoder3to8_accum

Overview:
- Inverse of the team's 8-to-3 priority encoder.
- Accepts a stream of 3-bit indices over a valid/ready handshake and decodes each to one-hot.
- ORs the decoded bits into an 8-bit request vector over a frame.
- Presents the completed vector downstream with its own valid/ready handshake.
- Rebuilds the bit-vectors that encoder consumers need, e.g. for arbitration-mask and request-set regeneration.

Parameters:
- SEL_W, 3, index width; output vector width VEC_W = 2**SEL_W (localparam, 8 at default).
- FRAME_LEN, 4, codes per frame before forced close; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_code is valid
- in_ready  output  1  block can accept a code
- in_code  input  SEL_W  index to decode
- in_last  input  1  closes the frame with this code
- out_valid  output  1  out_vec and out_count are valid
- out_ready  input  1  downstream accepts the frame
- out_vec  output  VEC_W  OR of decoded one-hots for the frame
- out_count  output  CNT_W  codes accepted in the frame; CNT_W = $clog2(FRAME_LEN+1)

Behaviour:
- One clock, clk. rst_n is asynchronous, active-low, and applied immediately.
- Reset values: state=IDLE, acc=0, cnt=0, out_valid=0, out_vec=0, out_count=0, in_ready=1 (in_ready is combinational from state).
- Input handshake: an input transfer occurs when in_valid && in_ready. A code is accepted only on a transfer.
- Output handshake: an output transfer occurs when out_valid && out_ready.
- States:
  - IDLE: acc=0, cnt=0, in_ready=1. On an input transfer: acc |= onehot(in_code), cnt=1. If the frame closes, go to HOLD; else go to ACCUM.
  - ACCUM: in_ready=1. On an input transfer: acc |= onehot(in_code), cnt+=1. If the frame closes, go to HOLD.
  - HOLD: in_ready=0, out_valid=1. out_vec and out_count are registered from acc/cnt and stable until the output transfer. On the output transfer, clear acc and cnt and go to IDLE.
- Frame close: in_last=1 on a transfer, or the transfer makes cnt==FRAME_LEN. in_last and cnt==FRAME_LEN together count as a single close.
- Latency: out_valid rises the cycle after the closing code transfers. After an output transfer, in_ready returns high the next cycle; there is no same-cycle refill.
- Duplicate codes in a frame: the bit stays set and cnt still increments.
- in_code values are always in range: SEL_W bits fully decode VEC_W.
- in_valid low: state, acc and cnt hold.
- in_last is ignored when in_valid=0.
- FRAME_LEN=1: every code closes a frame, so IDLE goes straight to HOLD.
- Reset asserted mid-frame or in HOLD: the partial frame is discarded and out_valid drops immediately.
- out_ready held high in IDLE or ACCUM has no effect.

Optional Feature:
- Macro: DECODE_ACCUM_DUP_DETECT_EN.
- Defined:
  - Adds output out_dup (1 bit, reset 0), valid with out_vec.
  - out_dup=1 if any accepted code in the frame hit a bit already set in acc, including a duplicate on the closing code.
  - Cleared with acc on the output transfer.
- Undefined: the port and logic are absent, and all other behaviour is identical.

Decomposition:
- Package decoder_pkg holds:
  - SEL_W default constant.
  - state typedef enum {IDLE, ACCUM, HOLD}.
  - onehot function or VEC_W-related constants.
- Sub-module decoder3to8 is natural: purely combinational SEL_W-to-VEC_W one-hot decode with an enable. It is instantiated once on the input path.

Test Plan:
- Reset, then codes 3,0,7,5 with no in_last (FRAME_LEN=4) -> one cycle after the 4th transfer: out_valid=1, out_vec=8'b10101001, out_count=4, in_ready=0.
- Codes 2,2 with in_last on the second -> out_vec=8'b00000100, out_count=2; with the macro, out_dup=1.
- In HOLD with out_ready=0 for 5 cycles and in_valid=1 code 6 -> out_vec stable, no code accepted. Then out_ready=1 -> IDLE next cycle, and code 6 is accepted into a fresh frame.
- Single code 4 with in_last=1 from IDLE -> HOLD, out_vec=8'b00010000, out_count=1. Repeat with FRAME_LEN=1 and no in_last -> same result.
- Two codes accepted, then rst_n pulsed low between clock edges -> out_valid=0, acc=0 immediately. Next frame 1,1,1,1 -> out_vec=8'b00000010, out_count=4.
- Gaps of in_valid=0 between codes 0,1 -> acc held through the gaps; the closing code 1 with in_last gives out_vec=8'b00000011, out_count=2.
